dmem_arbiter: RTL and testbench

//  Shares the single-port synchronous data BRAM (dmem) between the load unit and
//  the store-buffer drain port. One access per cycle: loads have priority, and a

---
 rtl/dmem_arbiter.sv | 72 +++++++
 tb/tb_dmem_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Purpose: shares the single-port data BRAM between the load unit and the store-buffer drain.
// Latency: grants are combinational; load data returns 1 cycle after ld_gnt.
// Backpressure: loads win; a held store is forced through after STARVE_MAX consecutive denials.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ld_req,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic              o_ld_gnt,
  input  logic              i_ld_kill,
  output logic              o_ld_rvalid,
  output logic [DATA_W-1:0] o_ld_rdata,
  input  logic              i_st_req,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_wdata,
  output logic              o_st_gnt,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  logic       r_rd_pend;
  logic       w_force_st;
  logic       w_st_gnt;
  logic       w_ld_gnt;

  // Grant decision: a store only wins when no load is asking, or when it has starved long enough.
  always_comb begin
    w_force_st = i_st_req && (r_starve_cnt == LP_STARVE_MAX);
    w_st_gnt   = !i_reset && i_st_req && (!i_ld_req || w_force_st);
    w_ld_gnt   = !i_reset && i_ld_req && !w_st_gnt;
  end

  assign o_st_gnt    = w_st_gnt;
  assign o_ld_gnt    = w_ld_gnt;
  // With no grant the port still presents the load address; a spurious read is harmless.
  assign o_mem_addr  = w_st_gnt ? i_st_addr : i_ld_addr;
  assign o_mem_wdata = i_st_wdata;
  assign o_mem_we    = w_st_gnt;
  // A flush kills only the return landing this cycle; reset drops any in-flight return.
  assign o_ld_rvalid = !i_reset && r_rd_pend && !i_ld_kill;
  assign o_ld_rdata  = i_mem_rdata;

  // Starvation counter: counts consecutive denials of a held store, clears when it drops or wins.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve_cnt <= 4'd0;
    end else if (w_st_gnt || !i_st_req) begin
      r_starve_cnt <= 4'd0;
    end else if (r_starve_cnt != LP_STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Return tracker: the BRAM answers one cycle after the load was granted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_ld_gnt;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a per-cycle vector table with hand-computed expectations,
// driven against a small synchronous BRAM model, plus a hand-written contention run.
// Inputs change on the falling edge; outputs are compared 1ns later.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req, ld_gnt, ld_kill, ld_rvalid;
  logic [31:0] ld_addr, ld_rdata;
  logic        st_req, st_gnt;
  logic [31:0] st_addr, st_wdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [256];

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst;
    logic        lr;
    logic [31:0] la;
    logic        lk;
    logic        sr;
    logic [31:0] sa;
    logic [31:0] sd;
    logic        gl;
    logic        gs;
    logic        rv;
    logic [31:0] ea;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_ld_req   (ld_req),
    .i_ld_addr  (ld_addr),
    .o_ld_gnt   (ld_gnt),
    .i_ld_kill  (ld_kill),
    .o_ld_rvalid(ld_rvalid),
    .o_ld_rdata (ld_rdata),
    .i_st_req   (st_req),
    .i_st_addr  (st_addr),
    .i_st_wdata (st_wdata),
    .o_st_gnt   (st_gnt),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_mem_we   (mem_we),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous read-first BRAM: write lands at the edge, read data appears after the edge.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic add(input logic rst, input logic lr, input logic [31:0] la, input logic lk,
                     input logic sr, input logic [31:0] sa, input logic [31:0] sd,
                     input logic gl, input logic gs, input logic rv,
                     input logic [31:0] ea, input logic [31:0] ed);
    vec_t v;
    v.rst = rst; v.lr = lr; v.la = la; v.lk = lk; v.sr = sr; v.sa = sa; v.sd = sd;
    v.gl = gl; v.gs = gs; v.rv = rv; v.ea = ea; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; ld_req = v.lr; ld_addr = v.la; ld_kill = v.lk;
    st_req = v.sr; st_addr = v.sa; st_wdata = v.sd;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'hDEADBEEF;
    mem[8'h10] = 32'h11110010;
    mem_rdata = 32'h0;
    reset = 1'b1; ld_req = 1'b0; ld_addr = 32'h0; ld_kill = 1'b0;
    st_req = 1'b0; st_addr = 32'h0; st_wdata = 32'h0;
    repeat (2) @(negedge clk);

    //   rst lr la        lk sr sa        sd            gl gs rv ea        ed
    // reset state with both requests asserted
    add(1, 1, 32'h04, 0, 1, 32'h08, 32'h0,        0, 0, 0, 32'h04, 32'h0);
    add(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 32'h0);
    // single load, 1-cycle return
    add(0, 1, 32'h04, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h04, 32'h0);
    add(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        0, 0, 1, 32'h00, 32'hDEADBEEF);
    // store then load-after-store to the same address
    add(0, 0, 32'h00, 0, 1, 32'h08, 32'h12345678, 0, 1, 0, 32'h08, 32'h0);
    add(0, 1, 32'h08, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h08, 32'h0);
    add(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        0, 0, 1, 32'h00, 32'h12345678);
    // contention for 10 cycles: L,L,L,L,S,L,L,L,L,S
    add(0, 1, 32'h10, 0, 1, 32'h20, 32'hA5A5A5A5, 1, 0, 0, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 32'h10, 0, 1, 32'h20, 32'hA5A5A5A5, 1, 0, 1, 32'h10, 32'h11110010);
    add(0, 1, 32'h10, 0, 1, 32'h20, 32'hA5A5A5A5, 0, 1, 1, 32'h20, 32'h11110010);
    add(0, 1, 32'h10, 0, 1, 32'h20, 32'hA5A5A5A5, 1, 0, 0, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 32'h10, 0, 1, 32'h20, 32'hA5A5A5A5, 1, 0, 1, 32'h10, 32'h11110010);
    add(0, 1, 32'h10, 0, 1, 32'h20, 32'hA5A5A5A5, 0, 1, 1, 32'h20, 32'h11110010);
    // read back the forced store
    add(0, 1, 32'h20, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h20, 32'h0);
    add(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        0, 0, 1, 32'h00, 32'hA5A5A5A5);
    // kill drops the due return but a load granted in the kill cycle returns normally
    add(0, 1, 32'h04, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h04, 32'h0);
    add(0, 1, 32'h10, 1, 0, 32'h00, 32'h0,        1, 0, 0, 32'h10, 32'h0);
    add(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        0, 0, 1, 32'h00, 32'h11110010);
    // store drops for one cycle at count 3: the next forced store waits 4 more denials
    add(0, 1, 32'h10, 0, 1, 32'h30, 32'hC3C3C3C3, 1, 0, 0, 32'h10, 32'h0);
    add(0, 1, 32'h10, 0, 1, 32'h30, 32'hC3C3C3C3, 1, 0, 1, 32'h10, 32'h11110010);
    add(0, 1, 32'h10, 0, 1, 32'h30, 32'hC3C3C3C3, 1, 0, 1, 32'h10, 32'h11110010);
    add(0, 1, 32'h10, 0, 0, 32'h30, 32'hC3C3C3C3, 1, 0, 1, 32'h10, 32'h11110010);
    for (int i = 0; i < 4; i++)
      add(0, 1, 32'h10, 0, 1, 32'h30, 32'hC3C3C3C3, 1, 0, 1, 32'h10, 32'h11110010);
    add(0, 1, 32'h10, 0, 1, 32'h30, 32'hC3C3C3C3, 0, 1, 1, 32'h30, 32'h11110010);
    add(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 32'h0);
    // reset mid-operation: load in flight, store pending at count 3
    add(0, 1, 32'h04, 0, 1, 32'h40, 32'h5A5A5A5A, 1, 0, 0, 32'h04, 32'h0);
    add(0, 1, 32'h04, 0, 1, 32'h40, 32'h5A5A5A5A, 1, 0, 1, 32'h04, 32'hDEADBEEF);
    add(0, 1, 32'h04, 0, 1, 32'h40, 32'h5A5A5A5A, 1, 0, 1, 32'h04, 32'hDEADBEEF);
    add(1, 1, 32'h04, 0, 1, 32'h40, 32'h5A5A5A5A, 0, 0, 0, 32'h04, 32'h0);
    add(0, 1, 32'h04, 0, 1, 32'h40, 32'h5A5A5A5A, 1, 0, 0, 32'h04, 32'h0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 32'h04, 0, 1, 32'h40, 32'h5A5A5A5A, 1, 0, 1, 32'h04, 32'hDEADBEEF);
    add(0, 1, 32'h04, 0, 1, 32'h40, 32'h5A5A5A5A, 0, 1, 1, 32'h40, 32'hDEADBEEF);
    add(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk("ld_gnt",   i, {31'h0, ld_gnt},    {31'h0, vecs[i].gl});
      chk("st_gnt",   i, {31'h0, st_gnt},    {31'h0, vecs[i].gs});
      chk("mem_we",   i, {31'h0, mem_we},    {31'h0, vecs[i].gs});
      chk("mem_addr", i, mem_addr,           vecs[i].ea);
      chk("ld_rvalid",i, {31'h0, ld_rvalid}, {31'h0, vecs[i].rv});
      if (vecs[i].rv) chk("ld_rdata", i, ld_rdata, vecs[i].ed);
      if (vecs[i].gs) chk("mem_wdata", i, mem_wdata, vecs[i].sd);
      @(negedge clk);
    end

    // Hand sequence: 15 cycles of sustained contention from a cleared counter.
    // Stores must land on cycles 4, 9 and 14 and never together with a load.
    begin
      int n_st;
      n_st = 0;
      for (int c = 0; c < 15; c++) begin
        reset = 1'b0; ld_req = 1'b1; ld_addr = 32'h04; ld_kill = 1'b0;
        st_req = 1'b1; st_addr = 32'h50; st_wdata = 32'h00000050 + 32'(c);
        #1;
        chk("contend_st_gnt", 1000 + c, {31'h0, st_gnt}, {31'h0, (c % 5) == 4});
        chk("contend_ld_gnt", 1000 + c, {31'h0, ld_gnt}, {31'h0, (c % 5) != 4});
        if (st_gnt) n_st++;
        @(negedge clk);
      end
      chk("contend_store_count", 1015, 32'(n_st), 32'd3);
      ld_req = 1'b0; st_req = 1'b0;
      @(negedge clk);
      // last store (cycle 14) wrote 0x50+14 to word 0x50
      ld_req = 1'b1; ld_addr = 32'h50;
      @(negedge clk);
      ld_req = 1'b0;
      #1;
      chk("contend_readback_vld", 1016, {31'h0, ld_rvalid}, 32'd1);
      chk("contend_readback_dat", 1016, ld_rdata, 32'h0000005E);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
